// File: rtl/fp_div_iter.sv
`default_nettype none
// ============================================================================
// fp_div_iter : iterative IEEE754 single-precision divider, one quotient bit
//               per cycle, truncating, with denormal flush and status flags.
// Revision    : 1.0
// ============================================================================
module fp_div_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [4:0] C_LAST_ITER = 5'd24;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_sign;
  logic [7:0]  r_exp_a;
  logic [7:0]  r_exp_b;
  logic [22:0] r_frac_b;
  logic [24:0] r_rem;
  logic [24:0] r_q;
  logic [4:0]  r_cnt;

  logic        w_in_zero;
  logic [24:0] w_sb;
  logic        w_ge;
  logic [24:0] w_sel;
  logic [9:0]  w_e;
  logic [22:0] w_frac;
  logic        w_ovf;
  logic        w_unf;

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

  // Zero-operand decision must use the live inputs: capture happens on the same edge.
  assign w_in_zero = (A[30:23] == 8'd0) || (B[30:23] == 8'd0);

  // Restoring step: partial remainder stays below SB, so the shifted value fits 25 bits.
  assign w_sb  = {2'b01, r_frac_b};
  assign w_ge  = (r_rem >= w_sb);
  assign w_sel = w_ge ? (r_rem - w_sb) : r_rem;

  assign w_e    = {2'b00, r_exp_a} - {2'b00, r_exp_b} + (r_q[24] ? 10'd127 : 10'd126);
  assign w_frac = r_q[24] ? r_q[23:1] : r_q[22:0];
  assign w_ovf  = !w_e[9] && (w_e[8:0] >= 9'd255);
  assign w_unf  = w_e[9] || (w_e == 10'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = w_in_zero ? NORM : DIV;
        end
      end
      DIV: begin
        if (r_cnt == C_LAST_ITER) begin
          w_next_state = NORM;
        end
      end
      NORM:    w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign      <= 1'b0;
      r_exp_a     <= 8'd0;
      r_exp_b     <= 8'd0;
      r_frac_b    <= 23'd0;
      r_rem       <= 25'd0;
      r_q         <= 25'd0;
      r_cnt       <= 5'd0;
      result      <= 32'd0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sign      <= A[31] ^ B[31];
            r_exp_a     <= A[30:23];
            r_exp_b     <= B[30:23];
            r_frac_b    <= B[22:0];
            r_rem       <= {2'b01, A[22:0]};
            r_q         <= 25'd0;
            r_cnt       <= 5'd0;
            result      <= 32'd0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        DIV: begin
          r_q   <= {r_q[23:0], w_ge};
          r_rem <= {w_sel[23:0], 1'b0};
          r_cnt <= r_cnt + 5'd1;
        end
        NORM: begin
          overflow    <= 1'b0;
          underflow   <= 1'b0;
          div_by_zero <= 1'b0;
          // A zero divisor wins over a zero dividend, so 0/0 yields infinity.
          if (r_exp_b == 8'd0) begin
            div_by_zero <= 1'b1;
            result      <= {r_sign, 8'hFF, 23'd0};
          end else if (r_exp_a == 8'd0) begin
            result      <= {r_sign, 31'd0};
          end else if (w_ovf) begin
            overflow    <= 1'b1;
            result      <= {r_sign, 8'hFF, 23'd0};
          end else if (w_unf) begin
            underflow   <= 1'b1;
            result      <= {r_sign, 31'd0};
          end else begin
            result      <= {r_sign, w_e[7:0], w_frac};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
